// File: rtl/conv_result_collector.sv
// Output-side collector for the 1-D systolic convolution array: tags each fed sample,
// captures the array result ARRAY_LATENCY cycles later, drops warm-up results, buffers the rest.
module conv_result_collector #(
  parameter int DATA_W        = 32,
  parameter int TAPS          = 3,
  parameter int ARRAY_LATENCY = 10,
  parameter int DEPTH         = 16,
  parameter int LEN_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  frame_len_i,
  input  logic              in_fire_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] array_y_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              done_o,
  output logic              overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(DEPTH + ARRAY_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [LEN_W-1:0]           idx_q, idx_d;
  logic                       overflow_q, overflow_d;
  logic [ARRAY_LATENCY-1:0]   tagValid_q, tagKeep_q, tagLast_q;
  logic [DATA_W:0]            mem_q [DEPTH];
  logic [PTR_W-1:0]           wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]           count_q;

  logic                       startOk, fire, keepIn, lastIn;
  logic                       capture, full, push, pop, dropped;
  logic [SUM_W-1:0]           inflightKeep;

  assign startOk = (state_q == IDLE) && start_i && (frame_len_i >= LEN_W'(TAPS));
  assign fire    = (state_q == RUN) && in_fire_i;
  assign keepIn  = fire && (idx_q >= LEN_W'(TAPS - 1));
  assign lastIn  = fire && (idx_q == len_q - 1'b1);

  assign capture = tagValid_q[ARRAY_LATENCY-1] && tagKeep_q[ARRAY_LATENCY-1];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop     = m_valid_o && m_ready_i;
  assign push    = capture && (!full || pop);
  assign dropped = capture && full && !pop;

  // Kept results still travelling through the array count against FIFO space,
  // because the array cannot be stalled once a sample has entered it.
  always_comb begin
    inflightKeep = '0;
    for (int k = 0; k < ARRAY_LATENCY; k++) begin
      inflightKeep = inflightKeep + SUM_W'(tagValid_q[k] & tagKeep_q[k]);
    end
  end

  assign in_ready_o = (state_q == RUN) &&
                      ((SUM_W'(count_q) + inflightKeep) < SUM_W'(DEPTH));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    done_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (startOk) begin
          len_d      = frame_len_i;
          idx_d      = '0;
          overflow_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (in_fire_i) begin
          idx_d = idx_q + 1'b1;
          if (lastIn) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tagValid_q == '0) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (dropped) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      tagValid_q <= '0;
      tagKeep_q  <= '0;
      tagLast_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      tagValid_q <= (tagValid_q << 1) | ARRAY_LATENCY'(fire);
      tagKeep_q  <= (tagKeep_q << 1) | ARRAY_LATENCY'(keepIn);
      tagLast_q  <= (tagLast_q << 1) | ARRAY_LATENCY'(lastIn);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is unreset; outputs are gated by m_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {tagLast_q[ARRAY_LATENCY-1], array_y_i};
  end

  assign m_valid_o  = (count_q != '0);
  assign m_data_o   = m_valid_o ? mem_q[rdPtr_q][DATA_W-1:0] : '0;
  assign m_last_o   = m_valid_o ? mem_q[rdPtr_q][DATA_W] : 1'b0;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Bench for conv_result_collector: a queue-based cycle model checked every cycle,
// plus directed frames with hand-computed result values.
module tb_conv_result_collector;

  localparam int DATA_W = 32;
  localparam int TAPS   = 3;
  localparam int LAT    = 10;
  localparam int DEPTH  = 16;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  frameLen;
  logic              inFire;
  logic              inReady;
  logic [DATA_W-1:0] arrayY;
  logic              mValid;
  logic              mReady;
  logic [DATA_W-1:0] mData;
  logic              mLast;
  logic              done;
  logic              overflow;

  conv_result_collector #(
    .DATA_W(DATA_W), .TAPS(TAPS), .ARRAY_LATENCY(LAT), .DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .frame_len_i(frameLen),
    .in_fire_i(inFire), .in_ready_o(inReady), .array_y_i(arrayY),
    .m_valid_o(mValid), .m_ready_i(mReady), .m_data_o(mData),
    .m_last_o(mLast), .done_o(done), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int due; bit keep; bit last; } tag_t;
  typedef struct { logic [DATA_W-1:0] data; bit last; } res_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  tag_t pending[$];
  res_t expQ[$];
  res_t outLog[$];
  bit   mRun = 0;
  bit   mOvf = 0;
  int   mN = 0;
  int   mIdx = 0;
  int   mDoneCycle = -1;
  int   doneAt = -1;
  int   lastFireCycle = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Model: fired samples become pending captures due LAT cycles later; kept ones
  // join an expected-output queue bounded at DEPTH entries.
  always @(negedge clk) begin : cmp
    int   keepPending;
    bit   expValid;
    bit   pop;
    bit   idle;
    res_t r;
    tag_t t;
    if (rst) begin
      checkOutput("rst_m_valid", mValid, 0);
      checkOutput("rst_in_ready", inReady, 0);
      checkOutput("rst_m_data", mData, 0);
      checkOutput("rst_m_last", mLast, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_overflow", overflow, 0);
      pending.delete();
      expQ.delete();
      mRun = 0;
      mOvf = 0;
      mIdx = 0;
      mDoneCycle = -1;
    end else begin
      keepPending = 0;
      foreach (pending[i]) if (pending[i].keep) keepPending++;
      expValid = (expQ.size() > 0);
      checkOutput("m_valid", mValid, expValid);
      if (expValid) begin
        checkOutput("m_data", mData, expQ[0].data);
        checkOutput("m_last", mLast, expQ[0].last);
      end
      checkOutput("in_ready", inReady, mRun && ((expQ.size() + keepPending) < DEPTH));
      checkOutput("done", done, cyc == mDoneCycle);
      checkOutput("overflow", overflow, mOvf);
      if (mValid && mReady) begin
        r.data = mData;
        r.last = mLast;
        outLog.push_back(r);
      end
      if (done) doneAt = cyc;
      pop = expValid && mReady;
      if (pop) void'(expQ.pop_front());
      if (pending.size() > 0 && pending[0].due == cyc) begin
        if (pending[0].keep) begin
          if (expQ.size() < DEPTH) begin
            r.data = arrayY;
            r.last = pending[0].last;
            expQ.push_back(r);
          end else begin
            mOvf = 1;
          end
        end
        void'(pending.pop_front());
      end
      idle = !mRun && (mDoneCycle < 0);
      if (cyc == mDoneCycle) mDoneCycle = -1;
      if (mRun && inFire) begin
        t.due  = cyc + LAT;
        t.keep = (mIdx >= TAPS - 1);
        t.last = (mIdx == mN - 1);
        pending.push_back(t);
        if (t.last) begin
          mRun = 0;
          mDoneCycle = cyc + LAT + 1;
        end
        mIdx++;
      end else if (idle && start && (int'(frameLen) >= TAPS)) begin
        mRun = 1;
        mN   = int'(frameLen);
        mIdx = 0;
        mOvf = 0;
      end
    end
    cyc++;
  end

  // Drives one cycle of inputs; array_y follows 100 + cycle number.
  task automatic applyStimulus(input bit s, input int len, input bit f, input bit mr);
    start    = s;
    frameLen = LEN_W'(len);
    inFire   = f;
    mReady   = mr;
    arrayY   = DATA_W'(100 + cyc);
    if (f) lastFireCycle = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic resetCycle();
    rst = 1'b1;
    start = 1'b0;
    inFire = 1'b0;
    mReady = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // mrMode: 0/1 fixed m_ready, 2 random m_ready.
  task automatic waitDone(input int budget, input int mrMode);
    for (int k = 0; k < budget && doneAt < 0; k++) begin
      applyStimulus(0, 0, 0, (mrMode == 2) ? 1'($urandom_range(0, 1)) : 1'(mrMode));
    end
    checkOutput("done_seen", doneAt >= 0, 1);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && mValid; k++) applyStimulus(0, 0, 0, 1);
    checkOutput("drain_empty", mValid, 0);
  endtask

  task automatic newFrame();
    outLog.delete();
    doneAt = -1;
  endtask

  initial begin
    int f0;
    int fired;
    int blocked;
    rst = 1'b1;
    start = 1'b0;
    frameLen = '0;
    inFire = 1'b0;
    mReady = 1'b0;
    arrayY = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1);

    $display("[TB] basic frame N=5");
    newFrame();
    applyStimulus(1, 5, 0, 1);
    f0 = cyc;
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1);
    waitDone(40, 1);
    drain(10);
    checkOutput("basic_count", outLog.size(), 3);
    if (outLog.size() == 3) begin
      checkOutput("basic_r0", outLog[0].data, 100 + f0 + 12);
      checkOutput("basic_r1", outLog[1].data, 100 + f0 + 13);
      checkOutput("basic_r2", outLog[2].data, 100 + f0 + 14);
      checkOutput("basic_last0", outLog[0].last, 0);
      checkOutput("basic_last1", outLog[1].last, 0);
      checkOutput("basic_last2", outLog[2].last, 1);
    end
    checkOutput("basic_done_latency", doneAt - lastFireCycle, 11);

    $display("[TB] illegal start and idle fires");
    newFrame();
    applyStimulus(1, 2, 0, 1);
    checkOutput("illegal_in_ready", inReady, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1);
    repeat (15) applyStimulus(0, 0, 0, 1);
    checkOutput("illegal_no_output", outLog.size(), 0);
    checkOutput("illegal_no_done", doneAt, -1);

    $display("[TB] backpressure N=40");
    newFrame();
    applyStimulus(1, 40, 0, 0);
    fired = 0;
    blocked = 0;
    f0 = -1;
    for (int k = 0; k < 200 && blocked < 20; k++) begin
      if (!inReady) blocked++;
      if (inReady && fired < 40) begin
        if (fired == 0) f0 = cyc;
        fired++;
        applyStimulus(0, 0, 1, 0);
      end else begin
        applyStimulus(0, 0, 0, 0);
      end
    end
    checkOutput("bp_fired_at_block", fired, 18);
    checkOutput("bp_no_overflow", overflow, 0);
    checkOutput("bp_fifo_full_valid", mValid, 1);
    for (int k = 0; k < 400 && fired < 40; k++) begin
      if (inReady) begin
        fired++;
        applyStimulus(0, 0, 1, 1);
      end else begin
        applyStimulus(0, 0, 0, 1);
      end
    end
    waitDone(100, 1);
    drain(40);
    checkOutput("bp_count", outLog.size(), 38);
    if (outLog.size() == 38) begin
      checkOutput("bp_first", outLog[0].data, 100 + f0 + 12);
      checkOutput("bp_last_flag", outLog[37].last, 1);
      checkOutput("bp_prev_last_flag", outLog[36].last, 0);
    end
    checkOutput("bp_overflow_end", overflow, 0);

    $display("[TB] forced overflow N=30");
    newFrame();
    applyStimulus(1, 30, 0, 0);
    f0 = cyc;
    for (int i = 0; i < 30; i++) applyStimulus(0, 0, 1, 0);
    waitDone(40, 0);
    checkOutput("ovf_set", overflow, 1);
    drain(40);
    checkOutput("ovf_count", outLog.size(), 16);
    if (outLog.size() == 16) begin
      checkOutput("ovf_first", outLog[0].data, 100 + f0 + 12);
      checkOutput("ovf_16th", outLog[15].data, 100 + f0 + 27);
      checkOutput("ovf_16th_last", outLog[15].last, 0);
    end
    newFrame();
    applyStimulus(1, 3, 0, 1);
    checkOutput("ovf_cleared", overflow, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1);
    waitDone(40, 1);
    drain(10);
    checkOutput("n3_count", outLog.size(), 1);

    $display("[TB] reset mid-frame N=10");
    newFrame();
    applyStimulus(1, 10, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 1);
    resetCycle();
    checkOutput("post_rst_in_ready", inReady, 0);
    repeat (20) applyStimulus(0, 0, 0, 1);
    checkOutput("post_rst_no_output", outLog.size(), 0);
    newFrame();
    applyStimulus(1, 3, 0, 1);
    f0 = cyc;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1);
    waitDone(40, 1);
    drain(10);
    checkOutput("fresh_count", outLog.size(), 1);
    if (outLog.size() == 1) begin
      checkOutput("fresh_data", outLog[0].data, 100 + f0 + 12);
      checkOutput("fresh_last", outLog[0].last, 1);
    end

    $display("[TB] gapped input N=8, random m_ready");
    newFrame();
    applyStimulus(1, 8, 0, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, 1'($urandom_range(0, 1)));
      applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)));
    end
    waitDone(60, 2);
    for (int k = 0; k < 60 && mValid; k++) applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)));
    checkOutput("gap_empty", mValid, 0);
    checkOutput("gap_count", outLog.size(), 6);
    if (outLog.size() == 6) begin
      checkOutput("gap_last", outLog[5].last, 1);
      checkOutput("gap_step", outLog[1].data - outLog[0].data, 2);
    end

    repeat (3) applyStimulus(0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_result_collector.md
# conv_result_collector

Output-side companion to the 1-D systolic convolution array. It tracks every sample the feeder pushes into the array and captures the array's `y_out` exactly `ARRAY_LATENCY` cycles later. It discards the `TAPS-1` warm-up results of each frame and buffers the valid convolution outputs in a FIFO with a ready/valid master port. It also produces a credit-based `in_ready` so the feeder never overruns the FIFO, because the array itself cannot stall.

## Interface
- `DATA_W`, 32, width of array result and output data
- `TAPS`, 3, number of PEs (kernel length); warm-up results per frame = `TAPS-1`
- `ARRAY_LATENCY`, 10, cycles from feeder `in_fire` to the matching `array_y` value (≥1)
- `DEPTH`, 16, FIFO entries, power of two, ≥2
- `LEN_W`, 16, width of `frame_len`

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  frame start pulse; honoured only in IDLE
- `frame_len`  in  `LEN_W`  input samples in the frame (N), sampled with `start`
- `in_fire`  in  1  feeder drove a new sample into the array this cycle
- `in_ready`  out  1  feeder may fire this cycle
- `array_y`  in  `DATA_W`  array output
- `m_valid`  out  1  output data valid
- `m_ready`  in  1  downstream accepts
- `m_data`  out  `DATA_W`  convolution result
- `m_last`  out  1  marks the last result of the frame
- `done`  out  1  one-cycle pulse when the last in-flight sample is captured
- `overflow`  out  1  sticky; a capture hit a full FIFO

## Operation
- **States**
  - IDLE: accepts `start` when `frame_len ≥ TAPS`; latches N, clears counters and `overflow`, moves to RUN. A `start` with `frame_len < TAPS` is ignored.
  - RUN: counts accepted samples. After sample index N-1 is accepted, moves to DRAIN.
  - DRAIN: waits until the tag delay line holds no valid tag, pulses `done`, then returns to IDLE.
- **Tagging**
  - Each `in_fire` in RUN with index i (0-based) enters a tag `{valid=1, keep=(i ≥ TAPS-1), last=(i == N-1)}` into an `ARRAY_LATENCY`-deep shift line.
  - Cycles without a fire enter valid=0.
  - `in_fire` outside RUN is ignored; no tag is created.
- **Capture**
  - When the tag at the line output has valid && keep, `{last, array_y}` is pushed into the FIFO.
  - Tags with keep=0 are discarded.
- **Outputs per frame:** exactly N-TAPS+1 results, the last carrying `m_last=1`.
- **in_ready**
  - Formula: `in_ready = (state==RUN) && (fifo_count + inflight_keep < DEPTH)`.
  - `inflight_keep` is the number of keep=1 tags currently in the delay line.
  - Warm-up samples are never blocked, since their tags carry keep=0.
- **Overflow:** if a push finds the FIFO full with no pop that cycle, the datum is dropped and `overflow` sets. It clears only on an accepted `start` or on reset.
- **FIFO**
  - Registered storage with a `fifo_count` of 0..`DEPTH`.
  - Push and pop in the same cycle are both honoured, including when full or empty-with-bypass-disallowed.
  - `m_data`/`m_last` hold stable while `m_valid && !m_ready`.
- **Arithmetic:** no arithmetic on data; `array_y` passes through bit-exact. Counters are `LEN_W` bits, with no wrap within a legal frame.

## Timing
- **Reset values:** state IDLE; FIFO empty; tag line all invalid; `in_ready=0`, `m_valid=0`, `m_data=0`, `m_last=0`, `done=0`, `overflow=0`.
- **Start:** `start` accepted at cycle s; `in_ready` may be 1 from cycle s+1.
- **Capture:** `in_fire` at cycle t → `array_y` sampled at edge ending cycle t+`ARRAY_LATENCY` → `m_valid` high at t+`ARRAY_LATENCY`+1 at the earliest, if the FIFO was empty.
- **Done:** the last sample fires at cycle f → `done` is high in cycle f+`ARRAY_LATENCY`+1. The FIFO may still hold results at that point; `m_last` marks the true end.
- **Back-to-back frames:** a new `start` is accepted in the cycle after `done`. FIFO contents from the previous frame are preserved ahead of the new frame's results.
- **Reset mid-frame:** everything returns to reset values immediately; in-flight tags and buffered data are lost.

## Test plan
- **Basic frame:** N=5, `in_fire` on 5 consecutive cycles, bench drives `array_y=100+c` (c = cycle number), `m_ready=1`. Required: exactly 3 results, equal to `array_y` at fire cycles 2, 3, 4 plus `ARRAY_LATENCY`; `m_last` on the 3rd only; `done` at last fire +11.
- **Backpressure:** N=40, `m_ready=0` throughout. Required: `in_ready` drops once `fifo_count + inflight_keep = 16`; no `overflow`; draining then yields 38 results in order.
- **Forced overflow:** feeder ignores `in_ready`, N=30, `m_ready=0`. Required: `overflow=1` after the 17th kept capture, FIFO holds the first 16 results, and `overflow` clears on the next accepted `start`.
- **Illegal start:** `start` with `frame_len=2` → remains IDLE, `in_ready=0`. `in_fire` in IDLE → no output, no `done`.
- **Reset mid-frame:** assert `rst` 3 cycles after the 4th fire of N=10 → all outputs return to reset values. A fresh N=3 frame then yields exactly 1 result with `m_last=1`.
- **Gapped input with random `m_ready`:** N=8, fires on alternate cycles → 6 results, each matching `array_y` at fire+`ARRAY_LATENCY`; data stable while stalled.
